drenaje_salida: RTL and testbench

//  Egress drain stage after the 4x4 switch core. Pops the four output FIFOs
//  (FIFO4..FIFO7) in round-robin order. Serialises their 10-bit words onto a

---
 rtl/drenaje_salida.sv | 135 +++++++++++++
 tb/tb_drenaje_salida.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drenaje_salida.sv
// Egress drain stage: round-robin pops of four output FIFOs, serialised onto
// one valid/ready port, with per-port saturating word counters and a sticky
// flag for words whose destination field disagrees with their source FIFO.
module drenaje_salida #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          fifo_empty,
  input  logic [4*DATA_W-1:0] fifo_data,
  output logic [3:0]          pop,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_port,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                cnt_clr,
  output logic [4*CNT_W-1:0]  word_cnt,
  output logic                dest_err
);

  typedef enum logic [1:0] {IDLE, POP, CAP, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        sel_reg;
  logic [1:0]        last_reg;
  logic [1:0]        winner;
  logic              any_ready;
  logic [DATA_W-1:0] out_data_reg;
  logic [1:0]        out_port_reg;
  logic              out_valid_reg;
  logic              dest_err_reg;
  logic              handshake;
  logic [DATA_W-1:0] cap_word;
  logic              cap_mismatch;

  assign any_ready    = |(~fifo_empty);
  assign handshake    = (state_reg == HOLD) && out_valid_reg && out_ready;
  assign cap_word     = fifo_data[sel_reg*DATA_W +: DATA_W];
  assign cap_mismatch = (cap_word[DATA_W-1:DATA_W-2] != sel_reg);

  // Round-robin winner: the port right after the last one served has the
  // highest priority, so scan downward and let the closest port overwrite.
  always_comb begin
    logic [1:0] idx;
    winner = '0;
    idx    = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_reg + 2'(k);
      if (!fifo_empty[idx]) winner = idx;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; empty flags only matter in IDLE or at a HOLD handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (any_ready) state_next = POP;
      POP:  state_next = CAP;
      CAP:  state_next = HOLD;
      HOLD: if (handshake) state_next = any_ready ? POP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pop strobe is a pure decode of the POP state, so it is high one cycle.
  always_comb begin
    pop = 4'b0000;
    if (state_reg == POP) pop = 4'b0001 << sel_reg;
  end

  // Arbitration pointers and the output word register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_reg       <= '0;
      last_reg      <= 2'd3;
      out_data_reg  <= '0;
      out_port_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (any_ready) sel_reg <= winner;
        POP:  last_reg <= sel_reg;
        CAP: begin
          out_data_reg  <= cap_word;
          out_port_reg  <= sel_reg;
          out_valid_reg <= 1'b1;
        end
        HOLD: if (handshake) begin
          out_valid_reg <= 1'b0;
          if (any_ready) sel_reg <= winner;
        end
        default: ;
      endcase
    end
  end

  // Sticky destination error; a clear in the same cycle takes precedence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 dest_err_reg <= 1'b0;
    else if (cnt_clr)                           dest_err_reg <= 1'b0;
    else if (state_reg == CAP && cap_mismatch)  dest_err_reg <= 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Saturating delivered-word counter for port gi; clear beats increment.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          cnt_reg <= '0;
        else if (cnt_clr)
          cnt_reg <= '0;
        else if (handshake && out_port_reg == 2'(gi) && cnt_reg != {CNT_W{1'b1}})
          cnt_reg <= cnt_reg + 1'b1;
      end

      assign word_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  assign out_data  = out_data_reg;
  assign out_port  = out_port_reg;
  assign out_valid = out_valid_reg;
  assign dest_err  = dest_err_reg;

endmodule

// File: tb/tb_drenaje_salida.sv
// Directed bench for drenaje_salida: behavioural FIFOs feed the main
// instance; a second instance with 2-bit counters checks saturation and
// asynchronous reset.
module tb_drenaje_salida;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fifo_empty;
  logic [39:0] fifo_data;
  logic [3:0]  pop;
  logic [9:0]  out_data;
  logic [1:0]  out_port;
  logic        out_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [31:0] word_cnt;
  logic        dest_err;

  logic        reset2;
  logic [3:0]  fifo_empty2;
  logic [39:0] fifo_data2;
  logic [3:0]  pop2;
  logic [9:0]  out_data2;
  logic [1:0]  out_port2;
  logic        out_valid2;
  logic        out_ready2;
  logic [7:0]  word_cnt2;
  logic        dest_err2;
  int          pops2 = 0;
  int          lim2  = 0;

  int checks = 0;
  int errors = 0;

  logic [9:0] mem [4][16];
  int         wp [4] = '{0, 0, 0, 0};
  int         rp [4] = '{0, 0, 0, 0};
  logic [9:0] rd_reg [4] = '{10'h0, 10'h0, 10'h0, 10'h0};

  logic [1:0] log_port [64];
  logic [9:0] log_data [64];
  int         n_log = 0;

  always #5 clk = ~clk;

  drenaje_salida #(.DATA_W(10), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .pop(pop), .out_data(out_data), .out_port(out_port), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .word_cnt(word_cnt), .dest_err(dest_err)
  );

  drenaje_salida #(.DATA_W(10), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset2), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
    .pop(pop2), .out_data(out_data2), .out_port(out_port2), .out_valid(out_valid2),
    .out_ready(out_ready2), .cnt_clr(1'b0), .word_cnt(word_cnt2), .dest_err(dest_err2)
  );

  // FIFO read model: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        rd_reg[i] <= mem[i][rp[i] % 16];
        rp[i]     <= rp[i] + 1;
      end
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]         = (wp[i] == rp[i]);
      fifo_data[i*10 +: 10] = rd_reg[i];
    end
  end

  // Saturation instance: FIFO5 always holds 10'h155 until lim2 words popped.
  always @(posedge clk) if (pop2[1]) pops2 <= pops2 + 1;
  assign fifo_empty2 = (pops2 < lim2) ? 4'b1101 : 4'b1111;
  assign fifo_data2  = {4{10'h155}};

  // Record every delivered word.
  always @(posedge clk) begin
    if (reset && out_valid && out_ready) begin
      log_port[n_log % 64] <= out_port;
      log_data[n_log % 64] <= out_data;
      n_log <= n_log + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop must be one-hot-or-zero and never fire against a stalled output.
  always @(negedge clk) begin
    if (reset) begin
      check("pop_onehot", 64'($onehot0(pop)), 64'd1);
      check("pop_stall", 64'(|pop && out_valid && !out_ready), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic [9:0] w);
    mem[p][wp[p] % 16] = w;
    wp[p] = wp[p] + 1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic wait_pop(input string tag);
    int n = 0;
    while (pop == 4'b0 && n < 50) begin tick(); n++; end
    check(tag, 64'(pop != 4'b0), 64'd1);
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    logic [9:0] exp_data [8];
    exp_data = '{10'h001, 10'h101, 10'h201, 10'h301, 10'h002, 10'h102, 10'h202, 10'h302};

    reset = 1'b0; reset2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1; cnt_clr = 1'b0;

    // Tests 1/3: two words per FIFO loaded while in reset.
    for (int i = 0; i < 4; i++)
      for (int k = 1; k <= 2; k++) push(i, 10'((i << 8) | k));
    repeat (3) tick();
    check("rst_pop", 64'(pop), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_cnt", 64'(word_cnt), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_port", 64'(out_port), 64'd0);
    check("rst_err", 64'(dest_err), 64'd0);
    @(negedge clk); reset = 1'b1; reset2 = 1'b1;
    tick();
    check("first_pop", 64'(pop), 64'b0001);
    tick();
    check("cap_no_valid", 64'(out_valid), 64'd0);
    tick();
    check("latency_valid", 64'(out_valid), 64'd1);
    check("first_data", 64'(out_data), 64'h001);
    n = 0;
    while (n_log < 8 && n < 100) begin tick(); n++; end
    check("rr_drained", 64'(n_log), 64'd8);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("rr_port%0d", j), 64'(log_port[j]), 64'(j % 4));
      check($sformatf("rr_data%0d", j), 64'(log_data[j]), 64'(exp_data[j]));
    end
    check("rr_cnt", 64'(word_cnt), 64'h02020202);
    check("rr_err", 64'(dest_err), 64'd0);

    // Test 2: single word on FIFO6.
    pulse_clr();
    check("clr_cnt", 64'(word_cnt), 64'd0);
    push(2, 10'h2A5);
    wait_pop("t2_pop_seen");
    check("t2_pop", 64'(pop), 64'b0100);
    tick();
    check("t2_pop_once", 64'(pop), 64'd0);
    wait_valid("t2_valid");
    check("t2_data", 64'(out_data), 64'h2A5);
    check("t2_port", 64'(out_port), 64'd2);
    tick();
    check("t2_cnt", 64'(word_cnt), 64'h00010000);
    check("t2_err", 64'(dest_err), 64'd0);

    // Test 4: back-pressure for 5 cycles with another port waiting.
    out_ready = 1'b0;
    push(0, 10'h012);
    push(1, 10'h145);
    wait_valid("t4_valid");
    check("t4_port", 64'(out_port), 64'd0);
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("t4_hold_data%0d", j), 64'(out_data), 64'h012);
      check($sformatf("t4_hold_pop%0d", j), 64'(pop), 64'd0);
      check($sformatf("t4_hold_cnt%0d", j), 64'(word_cnt[7:0]), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("t4_cnt0", 64'(word_cnt[7:0]), 64'd1);
    wait_valid("t4_valid1");
    check("t4_data1", 64'(out_data), 64'h145);
    tick();
    check("t4_cnt1", 64'(word_cnt[15:8]), 64'd1);

    // Test 5: wrong destination, sticky flag, clear; clear beats handshake.
    push(0, 10'h3FF);
    wait_valid("t5_valid");
    check("t5_err_set", 64'(dest_err), 64'd1);
    repeat (4) tick();
    check("t5_err_sticky", 64'(dest_err), 64'd1);
    pulse_clr();
    check("t5_err_clr", 64'(dest_err), 64'd0);
    check("t5_cnt_clr", 64'(word_cnt), 64'd0);
    push(3, 10'h30A);
    wait_valid("t5_valid3");
    base = n_log;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("t5_hs_taken", 64'(n_log - base), 64'd1);
    check("t5_clr_wins", 64'(word_cnt[31:24]), 64'd0);

    // Test 6: saturation at 3 with CNT_W=2, then async reset mid-HOLD.
    lim2 = 5;
    repeat (40) tick();
    check("t6_pops", 64'(pops2), 64'd5);
    check("t6_sat", 64'(word_cnt2), 64'hC);
    out_ready2 = 1'b0;
    lim2 = 6;
    n = 0;
    while (!out_valid2 && n < 50) begin tick(); n++; end
    check("t6_hold", 64'(out_valid2), 64'd1);
    #2 reset2 = 1'b0;
    #1;
    check("t6_async_valid", 64'(out_valid2), 64'd0);
    check("t6_async_cnt", 64'(word_cnt2), 64'd0);
    check("t6_async_pop", 64'(pop2), 64'd0);
    tick();
    reset2 = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
